// File: rtl/alu_pkg.sv
// Shared constants for the ALU: operation codes, status-flag bit positions, signedness-control bits.
// Latency: n/a (constants and a pure combinational helper).
// Backpressure: n/a.
package alu_pkg;

    // Operation select codes (mode input)
    localparam logic [3:0] OP_AND   = 4'b0000;
    localparam logic [3:0] OP_OR    = 4'b0001;
    localparam logic [3:0] OP_XOR   = 4'b0010;
    localparam logic [3:0] OP_NOR   = 4'b0011;
    localparam logic [3:0] OP_SLL   = 4'b0100;
    localparam logic [3:0] OP_SRL   = 4'b0101;
    localparam logic [3:0] OP_SLT   = 4'b0110;
    localparam logic [3:0] OP_ROL   = 4'b0111;
    localparam logic [3:0] OP_ADD   = 4'b1000;
    localparam logic [3:0] OP_SUB   = 4'b1001;
    localparam logic [3:0] OP_MUL   = 4'b1010;
    localparam logic [3:0] OP_DIV   = 4'b1011;
    localparam logic [3:0] OP_ROR   = 4'b1100;
    localparam logic [3:0] OP_PASSA = 4'b1101;
    localparam logic [3:0] OP_PASSB = 4'b1110;
    localparam logic [3:0] OP_ZERO  = 4'b1111;

    // Bit positions inside the 5-bit status vector {N, Z, C, V, EQ}
    localparam int FLG_EQ = 0;
    localparam int FLG_V  = 1;
    localparam int FLG_C  = 2;
    localparam int FLG_Z  = 3;
    localparam int FLG_N  = 4;

    // Bit positions inside the 3-bit signedness control
    localparam int SGN_MUL = 0;
    localparam int SGN_DIV = 1;
    localparam int SGN_CMP = 2;

    // Rotate left by up to 31: the doubled word shifted left leaves the
    // rotated value in its upper half.
    function automatic logic [31:0] rotl32(input logic [31:0] v, input logic [4:0] s);
        logic [63:0] d;
        d = {v, v} << s;
        return d[63:32];
    endfunction

    // Rotate right by up to 31: same trick, rotated value lands in the lower half.
    function automatic logic [31:0] rotr32(input logic [31:0] v, input logic [4:0] s);
        logic [63:0] d;
        d = {v, v} >> s;
        return d[31:0];
    endfunction

endpackage

// File: rtl/alu_muldiv.sv
// Combinational 32x32->64 multiply and 32/32 divide, each signed or unsigned.
// Latency: 0 cycles (purely combinational; the parent registers the result).
// Backpressure: none.
// Ports: a, b operands; sgn_mul / sgn_div select signed operation;
//        prod = full 64-bit product; quo / rem = quotient and remainder.
module alu_muldiv (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        sgn_mul,
    input  logic        sgn_div,
    output logic [63:0] prod,
    output logic [31:0] quo,
    output logic [31:0] rem
);

    // Multiply: sign- or zero-extend both operands to 64 bits; the low 64 bits
    // of the extended product are correct for both signed and unsigned cases,
    // so one multiplier serves both.
    logic [63:0] a_ext;
    logic [63:0] b_ext;

    assign a_ext = sgn_mul ? {{32{a[31]}}, a} : {32'h0, a};
    assign b_ext = sgn_mul ? {{32{b[31]}}, b} : {32'h0, b};
    assign prod  = a_ext * b_ext;

    // Divide: run an unsigned divider on magnitudes, then restore signs.
    // Quotient is negative when operand signs differ (truncation toward zero);
    // remainder follows the dividend's sign.
    logic        a_neg;
    logic        b_neg;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [31:0] q_mag;
    logic [31:0] r_mag;

    assign a_neg = sgn_div & a[31];
    assign b_neg = sgn_div & b[31];
    assign a_mag = a_neg ? (~a + 32'd1) : a;
    assign b_mag = b_neg ? (~b + 32'd1) : b;
    assign q_mag = (b == 32'h0) ? 32'h0 : (a_mag / b_mag);
    assign r_mag = (b == 32'h0) ? 32'h0 : (a_mag % b_mag);

    always_comb begin
        quo = (a_neg ^ b_neg) ? (~q_mag + 32'd1) : q_mag;
        rem = a_neg ? (~r_mag + 32'd1) : r_mag;
        if (b == 32'h0) begin
            // Divide by zero: all-ones quotient, dividend passes through as remainder
            quo = 32'hFFFF_FFFF;
            rem = a;
        end else if (sgn_div && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF)) begin
            // Most-negative / -1 does not fit; pinned to the wrapped value
            quo = 32'h8000_0000;
            rem = 32'h0;
        end
    end

endmodule

// File: rtl/alu_core.sv
// 32-bit ALU with registered 64-bit result and {N,Z,C,V,EQ} status (flags update on ADD/SUB only).
// Latency: 1 cycle from A/B/mode/flag to ALU_out, AHigh, flagOut; every op incl. DIV is single-cycle.
// Backpressure: none; a new operation is accepted and a result produced every cycle.
// Ports: clk, rst (sync, active-high); A, B operands; mode op select; flag signedness
//        [0] mul [1] div [2] compare/arith-shift; ALU_out result; AHigh = ALU_out[63:32];
//        flagOut registered status.
module alu_core
    import alu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic [3:0]  mode,
    input  logic [2:0]  flag,
    output logic [63:0] ALU_out,
    output logic [31:0] AHigh,
    output logic [4:0]  flagOut
);

    logic [4:0]  shamt;
    logic [32:0] sum;
    logic [32:0] diff;
    logic [31:0] sra_val;
    logic        slt_val;
    logic [63:0] prod;
    logic [31:0] quo;
    logic [31:0] rem;
    logic [63:0] res;
    logic [4:0]  flag_nxt;
    logic        flag_upd;

    assign shamt = B[4:0];

    // 33-bit add/sub so bit 32 gives carry out / borrow directly
    assign sum  = {1'b0, A} + {1'b0, B};
    assign diff = {1'b0, A} - {1'b0, B};

    assign sra_val = $unsigned($signed(A) >>> shamt);
    assign slt_val = flag[SGN_CMP] ? ($signed(A) < $signed(B)) : (A < B);

    alu_muldiv u_muldiv (
        .a       (A),
        .b       (B),
        .sgn_mul (flag[SGN_MUL]),
        .sgn_div (flag[SGN_DIV]),
        .prod    (prod),
        .quo     (quo),
        .rem     (rem)
    );

    // Result select; 32-bit ops zero-extend into the high word
    always_comb begin
        res = '0;
        case (mode)
            OP_AND:   res = {32'h0, A & B};
            OP_OR:    res = {32'h0, A | B};
            OP_XOR:   res = {32'h0, A ^ B};
            OP_NOR:   res = {32'h0, ~(A | B)};
            OP_SLL:   res = {32'h0, A << shamt};
            OP_SRL:   res = {32'h0, flag[SGN_CMP] ? sra_val : (A >> shamt)};
            OP_SLT:   res = {63'h0, slt_val};
            OP_ROL:   res = {32'h0, rotl32(A, shamt)};
            OP_ADD:   res = {32'h0, sum[31:0]};
            OP_SUB:   res = {32'h0, diff[31:0]};
            OP_MUL:   res = prod;
            OP_DIV:   res = {rem, quo};
            OP_ROR:   res = {32'h0, rotr32(A, shamt)};
            OP_PASSA: res = {32'h0, A};
            OP_PASSB: res = {32'h0, B};
            OP_ZERO:  res = '0;
        endcase
    end

    // Status for ADD/SUB. C on SUB is "no borrow", i.e. A >= B unsigned.
    // Signed overflow: ADD when operands agree in sign but result differs;
    // SUB when operands differ in sign and result differs from A.
    always_comb begin
        flag_nxt = '0;
        flag_upd = (mode == OP_ADD) || (mode == OP_SUB);
        flag_nxt[FLG_EQ] = (A == B);
        if (mode == OP_SUB) begin
            flag_nxt[FLG_N] = diff[31];
            flag_nxt[FLG_Z] = (diff[31:0] == 32'h0);
            flag_nxt[FLG_C] = ~diff[32];
            flag_nxt[FLG_V] = (A[31] != B[31]) && (diff[31] != A[31]);
        end else begin
            flag_nxt[FLG_N] = sum[31];
            flag_nxt[FLG_Z] = (sum[31:0] == 32'h0);
            flag_nxt[FLG_C] = sum[32];
            flag_nxt[FLG_V] = (A[31] == B[31]) && (sum[31] != A[31]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ALU_out <= '0;
            flagOut <= '0;
        end else begin
            ALU_out <= res;
            if (flag_upd) begin
                flagOut <= flag_nxt;
            end
        end
    end

    assign AHigh = ALU_out[63:32];

endmodule

// File: tb/tb_alu_core.sv
// Bench for alu_core: reference model checked against the DUT every cycle, plus literal expectations.
// Latency: model tracks the one-cycle registered output.
// Backpressure: none.
module tb_alu_core;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] A;
    logic [31:0] B;
    logic [3:0]  mode;
    logic [2:0]  flag;
    logic [63:0] ALU_out;
    logic [31:0] AHigh;
    logic [4:0]  flagOut;

    int total = 0;
    int bad   = 0;

    logic [63:0] exp_out;
    logic [4:0]  exp_flg;
    bit          model_valid = 1'b0;

    always #5 clk = ~clk;

    alu_core dut (
        .clk     (clk),
        .rst     (rst),
        .A       (A),
        .B       (B),
        .mode    (mode),
        .flag    (flag),
        .ALU_out (ALU_out),
        .AHigh   (AHigh),
        .flagOut (flagOut)
    );

    // ---------------- reference model (plain integer arithmetic) ----------------
    function automatic logic [31:0] m_rot(input logic [31:0] a, input int unsigned s, input bit left);
        if (s == 0) return a;
        if (left) return (a << s) | (a >> (32 - s));
        return (a >> s) | (a << (32 - s));
    endfunction

    function automatic logic [63:0] model_res(input logic [31:0] a, input logic [31:0] b,
                                              input logic [3:0] m, input logic [2:0] f);
        int          sa;
        int          sb;
        int unsigned s;
        longint      p;
        int          q;
        int          r;
        logic [31:0] t;
        sa = a;
        sb = b;
        s  = b % 32;
        case (m)
            4'd0:  return {32'h0, a & b};
            4'd1:  return {32'h0, a | b};
            4'd2:  return {32'h0, a ^ b};
            4'd3:  return {32'h0, ~(a | b)};
            4'd4:  return {32'h0, a << s};
            4'd5: begin
                if (f[2]) t = 32'(sa >>> s);
                else      t = a >> s;
                return {32'h0, t};
            end
            4'd6: begin
                if (f[2]) return (sa < sb) ? 64'd1 : 64'd0;
                return (a < b) ? 64'd1 : 64'd0;
            end
            4'd7:  return {32'h0, m_rot(a, s, 1'b1)};
            4'd8:  return {32'h0, a + b};
            4'd9:  return {32'h0, a - b};
            4'd10: begin
                if (f[0]) begin
                    p = longint'(sa) * longint'(sb);
                    return p;
                end
                return {32'h0, a} * {32'h0, b};
            end
            4'd11: begin
                if (b == 0) return {a, 32'hFFFF_FFFF};
                if (f[1]) begin
                    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 64'h0000_0000_8000_0000;
                    q = sa / sb;
                    r = sa % sb;
                    return {32'(r), 32'(q)};
                end
                return {a % b, a / b};
            end
            4'd12: return {32'h0, m_rot(a, s, 1'b0)};
            4'd13: return {32'h0, a};
            4'd14: return {32'h0, b};
            default: return 64'h0;
        endcase
    endfunction

    function automatic logic [4:0] model_flg(input logic [31:0] a, input logic [31:0] b,
                                             input logic [3:0] m, input logic [4:0] prev);
        int          sa;
        int          sb;
        longint      wide;
        logic [31:0] r;
        bit          c;
        bit          v;
        sa = a;
        sb = b;
        if (m == 4'd8) begin
            r    = a + b;
            c    = ({32'h0, a} + {32'h0, b}) > 64'h0000_0000_FFFF_FFFF;
            wide = longint'(sa) + longint'(sb);
        end else if (m == 4'd9) begin
            r    = a - b;
            c    = (a >= b);
            wide = longint'(sa) - longint'(sb);
        end else begin
            return prev;
        end
        v = (wide > 64'sd2147483647) || (wide < -64'sd2147483648);
        return {r[31], r == 32'h0, c, v, a == b};
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            exp_out     <= '0;
            exp_flg     <= '0;
            model_valid <= 1'b1;
        end else if (model_valid) begin
            exp_out <= model_res(A, B, mode, flag);
            exp_flg <= model_flg(A, B, mode, exp_flg);
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Continuous compare, away from the active edge
    always @(negedge clk) begin
        if (model_valid) begin
            check("model ALU_out", ALU_out, exp_out);
            check("model AHigh", {32'h0, AHigh}, {32'h0, exp_out[63:32]});
            check("model flagOut", {59'h0, flagOut}, {59'h0, exp_flg});
        end
    end

    // Apply one operation and step past the edge that registers it
    task automatic step(input logic [31:0] a, input logic [31:0] b,
                        input logic [3:0] m, input logic [2:0] f);
        @(negedge clk);
        A    = a;
        B    = b;
        mode = m;
        flag = f;
        @(posedge clk);
        #1;
    endtask

    logic [31:0] ops_a [6];
    logic [31:0] ops_b [6];

    initial begin
        rst  = 1'b1;
        A    = '0;
        B    = '0;
        mode = '0;
        flag = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset ALU_out", ALU_out, 64'h0);
        check("reset flagOut", {59'h0, flagOut}, 64'h0);
        @(negedge clk);
        rst = 1'b0;

        // ADD overflow and carry
        step(32'h7FFF_FFFF, 32'h1, 4'b1000, 3'b000);
        check("add ovf result", ALU_out, 64'h0000_0000_8000_0000);
        check("add ovf flags", {59'h0, flagOut}, {59'h0, 5'b10010});
        step(32'hFFFF_FFFF, 32'h1, 4'b1000, 3'b000);
        check("add carry result", ALU_out, 64'h0);
        check("add carry flags", {59'h0, flagOut}, {59'h0, 5'b01100});

        // Reset wins over a pending ADD and clears held flags
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("mid reset ALU_out", ALU_out, 64'h0);
        check("mid reset AHigh", {32'h0, AHigh}, 64'h0);
        check("mid reset flagOut", {59'h0, flagOut}, 64'h0);
        @(negedge clk);
        rst = 1'b0;
        step(32'd5, 32'd3, 4'b1000, 3'b000);
        check("add 5+3", ALU_out, 64'd8);
        check("add 5+3 flags", {59'h0, flagOut}, 64'h0);

        // SUB equal operands, then a non-flag op holds flags
        step(32'h1234_5678, 32'h1234_5678, 4'b1001, 3'b000);
        check("sub eq result", ALU_out, 64'h0);
        check("sub eq flags", {59'h0, flagOut}, {59'h0, 5'b01101});
        step(32'h1234_5678, 32'h1234_5678, 4'b0010, 3'b000);
        check("xor holds flags", {59'h0, flagOut}, {59'h0, 5'b01101});
        step(32'd3, 32'd5, 4'b1001, 3'b000);
        check("sub borrow flags", {59'h0, flagOut}, {59'h0, 5'b10000});

        // MUL
        step(32'hFFFF_FFFF, 32'd2, 4'b1010, 3'b000);
        check("mul unsigned", ALU_out, 64'h0000_0001_FFFF_FFFE);
        check("mul unsigned AHigh", {32'h0, AHigh}, 64'h1);
        step(32'hFFFF_FFFF, 32'd2, 4'b1010, 3'b001);
        check("mul signed", ALU_out, 64'hFFFF_FFFF_FFFF_FFFE);

        // DIV
        step(32'd100, 32'd7, 4'b1011, 3'b000);
        check("div 100/7", ALU_out, 64'h0000_0002_0000_000E);
        step(32'hFFFF_FFF9, 32'd2, 4'b1011, 3'b010);
        check("div -7/2", ALU_out, 64'hFFFF_FFFF_FFFF_FFFD);
        step(32'd100, 32'd0, 4'b1011, 3'b000);
        check("div by zero", ALU_out, 64'h0000_0064_FFFF_FFFF);
        step(32'h8000_0000, 32'hFFFF_FFFF, 4'b1011, 3'b010);
        check("div min/-1", ALU_out, 64'h0000_0000_8000_0000);

        // Shifts and rotates
        step(32'h8000_0001, 32'd1, 4'b0100, 3'b000);
        check("sll", ALU_out, 64'h0000_0000_0000_0002);
        step(32'h8000_0001, 32'd1, 4'b0101, 3'b000);
        check("srl", ALU_out, 64'h0000_0000_4000_0000);
        step(32'h8000_0001, 32'd1, 4'b0101, 3'b100);
        check("sra", ALU_out, 64'h0000_0000_C000_0000);
        step(32'h8000_0001, 32'd1, 4'b0111, 3'b000);
        check("rol", ALU_out, 64'h0000_0000_0000_0003);
        step(32'h8000_0001, 32'd1, 4'b1100, 3'b000);
        check("ror", ALU_out, 64'h0000_0000_C000_0000);
        step(32'h8000_0001, 32'd32, 4'b0111, 3'b000);
        check("rol by 32 is 0", ALU_out, 64'h0000_0000_8000_0001);
        step(32'hFFFF_FFFF, 32'd1, 4'b0110, 3'b100);
        check("slt signed", ALU_out, 64'd1);
        step(32'hFFFF_FFFF, 32'd1, 4'b0110, 3'b000);
        check("slt unsigned", ALU_out, 64'd0);

        // Sweep every mode and signedness over a small operand table,
        // checked by the continuous compare
        ops_a = '{32'h0, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'h1234_5678, 32'hDEAD_BEEF};
        ops_b = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0000_0025, 32'h0000_0013};
        for (int m = 0; m < 16; m++) begin
            for (int i = 0; i < 6; i++) begin
                for (int j = 0; j < 6; j++) begin
                    step(ops_a[i], ops_b[j], 4'(m), 3'((i + j) % 8));
                end
            end
        end
        for (int k = 0; k < 300; k++) begin
            step($urandom, $urandom, 4'($urandom_range(0, 15)), 3'($urandom_range(0, 7)));
        end

        @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
